// File: rtl/bram_verify_seq_if.sv
// Host-side command/response handshake bundle for the BRAM verify sequencer.
interface bram_verify_seq_if #(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DATA_W = 16
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_data;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/bram_verify_seq.sv
// Port-A command sequencer for the RRAM-emulation BRAM bank: read, write,
// write-verify with bounded re-programming, and fill-to-top-of-memory.
module bram_verify_seq #(
  parameter int unsigned ADDR_W    = 9,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned READ_LAT  = 1,
  parameter int unsigned MAX_RETRY = 3
) (
  input  logic              clk,
  input  logic              rst,
  bram_verify_seq_if.slave  bus,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);

  localparam int unsigned WCNT_W  = (READ_LAT > 1) ? $clog2(READ_LAT + 1) : 1;
  localparam int unsigned RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_WVER  = 2'b10;
  localparam logic [1:0] OP_FILL  = 2'b11;

  typedef enum logic [2:0] {IDLE, WR, RD, RWAIT, CMP, FILL, RESP} state_t;

  state_t               state_q, state_d;
  logic [1:0]           op_q, op_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [DATA_W-1:0]    data_q, data_d;
  logic [RETRY_W-1:0]   retry_q, retry_d;
  logic [WCNT_W-1:0]    wcnt_q, wcnt_d;
  logic                 cmd_ready_q, cmd_ready_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]    rsp_data_q, rsp_data_d;
  logic                 rsp_err_q, rsp_err_d;
  logic                 mem_en_d, mem_we_d;
  logic [ADDR_W-1:0]    mem_addr_d;
  logic [DATA_W-1:0]    mem_din_d;

  logic accept, rsp_fire, wait_last, wait_to_cmp, match, retry_left, fill_last;

  assign accept      = bus.cmd_valid && cmd_ready_q;
  assign rsp_fire    = rsp_valid_q && bus.rsp_ready;
  assign wait_last   = (wcnt_q == WCNT_W'(READ_LAT));
  assign wait_to_cmp = (wcnt_q == WCNT_W'(READ_LAT - 1));
  assign match       = (mem_dout == data_q);
  assign retry_left  = (retry_q != RETRY_W'(MAX_RETRY));
  assign fill_last   = (mem_addr == {ADDR_W{1'b1}});

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      op_q        <= OP_READ;
      addr_q      <= '0;
      data_q      <= '0;
      retry_q     <= '0;
      wcnt_q      <= '0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      mem_en      <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_din     <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      retry_q     <= retry_d;
      wcnt_q      <= wcnt_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      mem_en      <= mem_en_d;
      mem_we      <= mem_we_d;
      mem_addr    <= mem_addr_d;
      mem_din     <= mem_din_d;
    end
  end

  // Next state; for write-verify the final read-latency cycle is CMP
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (accept) begin
               case (bus.cmd_op)
                 OP_READ: state_d = RD;
                 OP_FILL: state_d = FILL;
                 default: state_d = WR;
               endcase
             end
      WR:    state_d = (op_q == OP_WVER) ? RD : RESP;
      RD:    state_d = (op_q == OP_WVER && READ_LAT == 1) ? CMP : RWAIT;
      RWAIT: begin
               if (op_q == OP_WVER) begin
                 if (wait_to_cmp) state_d = CMP;
               end else if (wait_last) begin
                 state_d = RESP;
               end
             end
      CMP:   state_d = (match || !retry_left) ? RESP : WR;
      FILL:  if (fill_last) state_d = RESP;
      RESP:  if (rsp_fire) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of datapath and outputs; BRAM strobes follow the next state
  always_comb begin
    op_d        = op_q;
    addr_d      = addr_q;
    data_d      = data_q;
    retry_d     = retry_q;
    wcnt_d      = wcnt_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr;
    mem_din_d   = mem_din;
    cmd_ready_d = (state_d == IDLE);
    rsp_valid_d = (state_d == RESP);

    case (state_q)
      IDLE:  if (accept) begin
               op_d    = bus.cmd_op;
               addr_d  = bus.cmd_addr;
               data_d  = bus.cmd_data;
               retry_d = '0;
             end
      WR:    if (op_q == OP_WRITE) begin
               rsp_data_d = data_q;
               rsp_err_d  = 1'b0;
             end
      RD:    wcnt_d = WCNT_W'(1);
      RWAIT: begin
               wcnt_d = wcnt_q + WCNT_W'(1);
               if (op_q == OP_READ && wait_last) begin
                 rsp_data_d = mem_dout;
                 rsp_err_d  = 1'b0;
               end
             end
      CMP:   if (match || !retry_left) begin
               rsp_data_d = mem_dout;
               rsp_err_d  = !match;
             end else begin
               retry_d = retry_q + RETRY_W'(1);
             end
      FILL:  if (fill_last) begin
               rsp_data_d = data_q;
               rsp_err_d  = 1'b0;
             end
      default: ;
    endcase

    case (state_d)
      WR: begin
        mem_en_d   = 1'b1;
        mem_we_d   = 1'b1;
        mem_addr_d = addr_d;
        mem_din_d  = data_d;
      end
      RD: begin
        mem_en_d   = 1'b1;
        mem_addr_d = addr_d;
      end
      FILL: begin
        mem_en_d   = 1'b1;
        mem_we_d   = 1'b1;
        mem_addr_d = (state_q == FILL) ? mem_addr + ADDR_W'(1) : addr_d;
        mem_din_d  = data_d;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_bram_verify_seq.sv
// Self-checking bench: READ_LAT=1 instance checked against a command-level
// model every cycle, plus a READ_LAT=2 instance for latency and reset abort.
module tb_bram_verify_seq;

  localparam int unsigned AW   = 9;
  localparam int unsigned DW   = 16;
  localparam int unsigned RL1  = 1;
  localparam int unsigned RL2  = 2;
  localparam int unsigned MAXR = 3;
  localparam int unsigned NWORDS = 512;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bram_verify_seq_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();
  bram_verify_seq_if #(.ADDR_W(AW), .DATA_W(DW)) bus2 ();

  logic          mem_en1, mem_we1, mem_en2, mem_we2;
  logic [AW-1:0] mem_addr1, mem_addr2;
  logic [DW-1:0] mem_din1, mem_din2, dout1, dout2, r2;

  bram_verify_seq #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(RL1), .MAX_RETRY(MAXR)) dut (
    .clk(clk), .rst(rst), .bus(bus1),
    .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1),
    .mem_din(mem_din1), .mem_dout(dout1)
  );

  bram_verify_seq #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(RL2), .MAX_RETRY(MAXR)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2),
    .mem_en(mem_en2), .mem_we(mem_we2), .mem_addr(mem_addr2),
    .mem_din(mem_din2), .mem_dout(dout2)
  );

  // Bank models: writes store din, reads return the AND-combined (masked) word
  logic [DW-1:0] bank1 [NWORDS];
  logic [DW-1:0] bank2 [NWORDS];
  logic [DW-1:0] mask1 = 16'hFFFF;

  always @(posedge clk) begin
    if (mem_en1) begin
      if (mem_we1) bank1[mem_addr1] <= mem_din1;
      else         dout1 <= bank1[mem_addr1] & mask1;
    end
  end

  always @(posedge clk) begin
    if (mem_en2 && mem_we2)  bank2[mem_addr2] <= mem_din2;
    if (mem_en2 && !mem_we2) r2 <= bank2[mem_addr2];
    dout2 <= r2;
  end

  int n_chk = 0;
  int n_err = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
    end
  endfunction

  // Command-level model for the READ_LAT=1 instance
  logic [DW-1:0] sh [NWORDS];
  logic [DW-1:0] exp_data, exp_din;
  logic          exp_err;
  int            exp_lat, exp_wr, exp_rd, lo, hi;

  task automatic model(input logic [1:0] op, input logic [AW-1:0] a, input logic [DW-1:0] d);
    logic [DW-1:0] rb;
    logic          done;
    exp_din = d;
    exp_err = 1'b0;
    lo = int'(a);
    hi = int'(a);
    exp_wr = 0;
    exp_rd = 0;
    case (op)
      2'b00: begin
        exp_data = sh[a] & mask1;
        exp_rd = 1;
        exp_lat = 2 + RL1;
      end
      2'b01: begin
        sh[a] = d;
        exp_data = d;
        exp_wr = 1;
        exp_lat = 2;
      end
      2'b10: begin
        done = 1'b0;
        rb = '0;
        for (int k = 0; k <= MAXR; k++) begin
          if (!done) begin
            sh[a] = d;
            rb = d & mask1;
            exp_wr = k + 1;
            exp_rd = k + 1;
            done = (rb == d);
          end
        end
        exp_data = rb;
        exp_err = !done;
        exp_lat = 3 + RL1 + (exp_wr - 1) * (RL1 + 2);
      end
      default: begin
        for (int x = int'(a); x < NWORDS; x++) sh[x] = d;
        exp_data = d;
        exp_wr = NWORDS - int'(a);
        exp_lat = NWORDS - int'(a) + 1;
        hi = NWORDS - 1;
      end
    endcase
  endtask

  // Compare process for the READ_LAT=1 instance
  logic busy = 1'b0;
  logic post_hs = 1'b0;
  int   acc = 0;
  int   wr_cnt = 0, rd_cnt = 0, bad = 0;
  int   wr_base = 0, rd_base = 0, bad_base = 0;

  always @(negedge clk) begin
    if (mem_en1) begin
      if (mem_we1) begin
        wr_cnt++;
        if (mem_din1 != exp_din) bad++;
      end else begin
        rd_cnt++;
      end
      if (int'(mem_addr1) < lo || int'(mem_addr1) > hi) bad++;
    end
    if (post_hs) begin
      chk("cmd_ready_after_handshake", 32'(bus1.cmd_ready), 32'd1);
      chk("rsp_valid_after_handshake", 32'(bus1.rsp_valid), 32'd0);
      post_hs = 1'b0;
    end
    if (busy && cyc > acc) begin
      chk("cmd_ready_while_busy", 32'(bus1.cmd_ready), 32'd0);
      chk("rsp_valid_timing", 32'(bus1.rsp_valid), 32'((cyc - acc) >= exp_lat));
      if (bus1.rsp_valid) begin
        chk("rsp_data", 32'(bus1.rsp_data), 32'(exp_data));
        chk("rsp_err", 32'(bus1.rsp_err), 32'(exp_err));
        chk("mem_en_in_resp", 32'(mem_en1), 32'd0);
        chk("write_count", 32'(wr_cnt - wr_base), 32'(exp_wr));
        chk("read_count", 32'(rd_cnt - rd_base), 32'(exp_rd));
        chk("bad_access", 32'(bad - bad_base), 32'd0);
        if (bus1.rsp_ready) post_hs = 1'b1;
      end
    end
  end

  function automatic logic rdy(input int w);
    return (w == 1) ? bus1.cmd_ready : bus2.cmd_ready;
  endfunction

  function automatic logic vld(input int w);
    return (w == 1) ? bus1.rsp_valid : bus2.rsp_valid;
  endfunction

  task automatic set_cmd(input int w, input logic v, input logic [1:0] op,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (w == 1) begin
      bus1.cmd_valid = v; bus1.cmd_op = op; bus1.cmd_addr = a; bus1.cmd_data = d;
    end else begin
      bus2.cmd_valid = v; bus2.cmd_op = op; bus2.cmd_addr = a; bus2.cmd_data = d;
    end
  endtask

  task automatic set_rdy(input int w, input logic v);
    if (w == 1) bus1.rsp_ready = v;
    else        bus2.rsp_ready = v;
  endtask

  task automatic drive_cmd(input int w, input logic [1:0] op, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, output int t_acc);
    int n;
    @(posedge clk); #1;
    set_cmd(w, 1'b1, op, a, d);
    n = 0;
    while (!rdy(w) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) chk("accept_timeout", 32'd1, 32'd0);
    t_acc = cyc;
    @(posedge clk); #1;
    set_cmd(w, 1'b0, 2'b00, '0, '0);
  endtask

  task automatic wait_rsp(input int w, input int t_acc, input int hold,
                          output int lat, output logic [DW-1:0] data, output logic err);
    int n;
    n = 0;
    while (!vld(w) && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 2000) chk("response_timeout", 32'd1, 32'd0);
    lat  = cyc - t_acc;
    data = (w == 1) ? bus1.rsp_data : bus2.rsp_data;
    err  = (w == 1) ? bus1.rsp_err  : bus2.rsp_err;
    repeat (hold) begin
      @(posedge clk); #1;
    end
    set_rdy(w, 1'b1);
    @(posedge clk); #1;
    set_rdy(w, 1'b0);
  endtask

  task automatic run1(input logic [1:0] op, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input int hold, output int lat, output logic [DW-1:0] data, output logic err);
    int t;
    model(op, a, d);
    wr_base = wr_cnt;
    rd_base = rd_cnt;
    bad_base = bad;
    drive_cmd(1, op, a, d, t);
    acc = t;
    busy = 1'b1;
    wait_rsp(1, t, hold, lat, data, err);
    busy = 1'b0;
  endtask

  initial begin
    int            lat, t, nv, na;
    logic [DW-1:0] data;
    logic          err;

    for (int i = 0; i < NWORDS; i++) begin
      bank1[i] = '0;
      bank2[i] = '0;
      sh[i] = '0;
    end
    dout1 = '0;
    dout2 = '0;
    r2 = '0;
    exp_din = '0;
    lo = 0;
    hi = 0;
    set_cmd(1, 1'b0, 2'b00, '0, '0);
    set_cmd(2, 1'b0, 2'b00, '0, '0);
    set_rdy(1, 1'b0);
    set_rdy(2, 1'b0);

    // Reset values, then ready one cycle after release
    repeat (3) @(posedge clk);
    #1;
    chk("reset_cmd_ready", 32'(bus1.cmd_ready), 32'd0);
    chk("reset_rsp_valid", 32'(bus1.rsp_valid), 32'd0);
    chk("reset_rsp_data", 32'(bus1.rsp_data), 32'd0);
    chk("reset_rsp_err", 32'(bus1.rsp_err), 32'd0);
    chk("reset_mem_en", 32'(mem_en1), 32'd0);
    chk("reset_mem_we", 32'(mem_we1), 32'd0);
    chk("reset_mem_addr", 32'(mem_addr1), 32'd0);
    chk("reset_mem_din", 32'(mem_din1), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("ready_after_reset", 32'(bus1.cmd_ready), 32'd1);
    chk("ready_after_reset_2", 32'(bus2.cmd_ready), 32'd1);

    // Write then read back
    run1(2'b01, 9'h005, 16'h1234, 0, lat, data, err);
    chk("write_latency", 32'(lat), 32'd2);
    model(2'b00, 9'h005, 16'h0000);
    chk("model_read_data", 32'(exp_data), 32'h1234);
    run1(2'b00, 9'h005, 16'h0000, 0, lat, data, err);
    chk("read_latency", 32'(lat), 32'd3);
    chk("read_data", 32'(data), 32'h1234);

    // Write-verify against a stuck-low bit 0, then against a good bank
    mask1 = 16'hFFFE;
    run1(2'b10, 9'h010, 16'h0003, 0, lat, data, err);
    chk("model_wv_writes", 32'(exp_wr), 32'd4);
    chk("wv_stuck_err", 32'(err), 32'd1);
    chk("wv_stuck_data", 32'(data), 32'h0002);
    chk("wv_stuck_latency", 32'(lat), 32'd13);
    mask1 = 16'hFFFF;
    run1(2'b10, 9'h010, 16'h0003, 0, lat, data, err);
    chk("model_wv_good_writes", 32'(exp_wr), 32'd1);
    chk("wv_good_latency", 32'(lat), 32'd4);
    chk("wv_good_err", 32'(err), 32'd0);

    // Fill at the top of memory must not wrap to address 0
    run1(2'b11, 9'h1FE, 16'hA5A5, 0, lat, data, err);
    chk("model_fill_top_writes", 32'(exp_wr), 32'd2);
    chk("fill_top_latency", 32'(lat), 32'd3);
    run1(2'b00, 9'h000, 16'h0000, 0, lat, data, err);
    chk("addr0_untouched", 32'(data), 32'h0000);

    // Backpressure on a read of the filled top word
    run1(2'b00, 9'h1FF, 16'h0000, 5, lat, data, err);
    chk("bp_read_data", 32'(data), 32'hA5A5);

    // Full fill and spot read; masked write-verify mismatch
    run1(2'b11, 9'h000, 16'h5AC3, 0, lat, data, err);
    chk("model_fill_all_writes", 32'(exp_wr), 32'd512);
    chk("fill_all_latency", 32'(lat), 32'd513);
    run1(2'b00, 9'h123, 16'h0000, 0, lat, data, err);
    chk("fill_all_read", 32'(data), 32'h5AC3);
    mask1 = 16'hFF00;
    run1(2'b10, 9'h0AA, 16'h1234, 2, lat, data, err);
    chk("wv_mask_data", 32'(data), 32'h1200);
    chk("wv_mask_err", 32'(err), 32'd1);
    mask1 = 16'hFFFF;

    // READ_LAT=2 instance: write then read at the top address
    drive_cmd(2, 2'b01, 9'h1FF, 16'hBEEF, t);
    wait_rsp(2, t, 0, lat, data, err);
    chk("rl2_write_latency", 32'(lat), 32'd2);
    drive_cmd(2, 2'b00, 9'h1FF, 16'h0000, t);
    wait_rsp(2, t, 0, lat, data, err);
    chk("rl2_read_latency", 32'(lat), 32'd4);
    chk("rl2_read_data", 32'(data), 32'hBEEF);
    chk("rl2_read_err", 32'(err), 32'd0);

    // Reset during the read-wait of a write-verify aborts it silently
    drive_cmd(2, 2'b10, 9'h040, 16'h5A5A, t);
    while (cyc < t + 3) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_mem_en", 32'(mem_en2), 32'd0);
    chk("abort_mem_we", 32'(mem_we2), 32'd0);
    chk("abort_rsp_valid", 32'(bus2.rsp_valid), 32'd0);
    chk("abort_cmd_ready", 32'(bus2.cmd_ready), 32'd0);
    @(negedge clk);
    chk("abort_ready_after_release", 32'(bus2.cmd_ready), 32'd1);
    nv = 0;
    na = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus2.rsp_valid) nv++;
      if (mem_en2) na++;
    end
    chk("abort_no_response", 32'(nv), 32'd0);
    chk("abort_no_access", 32'(na), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
